exec_mc_ctrl: RTL and testbench



---
 rtl/exec_mc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_exec_mc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mc_ctrl.sv
// exec_mc_ctrl: issue/start/wait controller for multi-cycle execute units.
//
// The controller accepts one instruction at a time from the execute stage and
// sends a one-cycle start pulse to the selected unit. It holds the pipeline
// with wait_exec until that unit reports ready. It then captures the unit's
// result together with the destination tag and the FP-register flag.
//
// Optional feature: define EXEC_MC_TIMEOUT_EN to add a WAIT-cycle watchdog.
// When the limit is reached, the watchdog returns an all-ones result and
// pulses timeout. Without the macro, timeout is tied to 0 and WAIT has no
// cycle limit.
module exec_mc_ctrl #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 5,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic [NUM_UNITS-1:0]        issue_sel,
    input  logic [TAG_W-1:0]            issue_tag,
    input  logic                        issue_writef,
    output logic [NUM_UNITS-1:0]        unit_start,
    input  logic [NUM_UNITS-1:0]        unit_ready,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    output logic                        wait_exec,
    output logic [DATA_W-1:0]           result,
    output logic [TAG_W-1:0]            result_tag,
    output logic                        result_writef,
    output logic                        result_valid,
    output logic                        sel_err,
    output logic                        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_UNITS-1:0]  sel_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  writef_q;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_data;
    logic                  accept;
    logic                  bad_sel;
    logic                  capture;
    logic                  expire;

    // Returns true only when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [NUM_UNITS-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

`ifdef EXEC_MC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`endif

    // Selected unit's ready and data. sel_q is one-hot, so an AND-OR mux
    // needs no index decode. It also ignores the unselected units.
    always_comb begin
        sel_ready = |(unit_ready & sel_q);
        sel_data  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_q[i]) begin
                sel_data = sel_data | unit_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic plus the combinational start and wait outputs.
    always_comb begin
        state_nxt  = state;
        unit_start = '0;
        wait_exec  = 1'b0;
        accept     = 1'b0;
        bad_sel    = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue_valid && !stall && !flush) begin
                    if (is_onehot(issue_sel)) begin
                        accept    = 1'b1;
                        state_nxt = START;
                    end else begin
                        bad_sel = 1'b1;
                    end
                end
            end
            START: begin
                // A flush in this cycle does not cut this cycle's start pulse short.
                unit_start = sel_q;
                wait_exec  = 1'b1;
                state_nxt  = flush ? IDLE : WAIT;
            end
            WAIT: begin
                wait_exec = ~sel_ready;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (sel_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef EXEC_MC_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the unit select, tag and FP flag of the accepted instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            tag_q    <= '0;
            writef_q <= 1'b0;
        end else if (accept) begin
            sel_q    <= issue_sel;
            tag_q    <= issue_tag;
            writef_q <= issue_writef;
        end
    end

    // Result capture and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            result        <= '0;
            result_tag    <= '0;
            result_writef <= 1'b0;
            result_valid  <= 1'b0;
            sel_err       <= 1'b0;
        end else begin
            result_valid <= capture | expire;
            sel_err      <= bad_sel;
            if (capture) begin
                result        <= sel_data;
                result_tag    <= tag_q;
                result_writef <= writef_q;
            end else if (expire) begin
                result        <= '1;
                result_tag    <= tag_q;
                result_writef <= writef_q;
            end
        end
    end

`ifdef EXEC_MC_TIMEOUT_EN
    // WAIT watchdog. The counter clears on the START->WAIT transition and
    // advances on every WAIT cycle without ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !sel_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exec_mc_ctrl.sv
// Directed testbench for exec_mc_ctrl (4 units, 32-bit data, TIMEOUT=8).
// The bench changes inputs just after each falling edge and samples outputs
// 1 time unit later, well away from the rising edge.
module tb_exec_mc_ctrl;

    localparam int NU = 4;
    localparam int DW = 32;
    localparam int TW = 5;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              issue_valid;
    logic [NU-1:0]     issue_sel;
    logic [TW-1:0]     issue_tag;
    logic              issue_writef;
    logic [NU-1:0]     unit_start;
    logic [NU-1:0]     unit_ready;
    logic [NU*DW-1:0]  unit_data;
    logic              wait_exec;
    logic [DW-1:0]     result;
    logic [TW-1:0]     result_tag;
    logic              result_writef;
    logic              result_valid;
    logic              sel_err;
    logic              timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_high;

    exec_mc_ctrl #(
        .NUM_UNITS(NU),
        .DATA_W(DW),
        .TAG_W(TW),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_sel(issue_sel),
        .issue_tag(issue_tag),
        .issue_writef(issue_writef),
        .unit_start(unit_start),
        .unit_ready(unit_ready),
        .unit_data(unit_data),
        .wait_exec(wait_exec),
        .result(result),
        .result_tag(result_tag),
        .result_writef(result_writef),
        .result_valid(result_valid),
        .sel_err(sel_err),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs are set right after this point.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [NU-1:0] sel, input logic [TW-1:0] tag, input logic wf);
        issue_valid  = 1'b1;
        issue_sel    = sel;
        issue_tag    = tag;
        issue_writef = wf;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_sel    = '0;
        issue_tag    = '0;
        issue_writef = 1'b0;
        unit_ready   = '0;
        unit_data    = '0;

        // Reset state.
        repeat (3) cyc();
        #1;
        chk("rst_start",  unit_start, 0);
        chk("rst_wait",   wait_exec, 0);
        chk("rst_result", result, 0);
        chk("rst_tag",    result_tag, 0);
        chk("rst_rv",     result_valid, 0);
        chk("rst_selerr", sel_err, 0);
        chk("rst_tmo",    timeout, 0);
        rst = 1'b0;

        // Test 1: unit 2, ready already high, minimum latency.
        cyc();
        unit_data[2*DW +: DW] = 32'h3F80_0000;
        unit_ready = 4'b0100;
        issue(4'b0100, 5'd7, 1'b1);
        #1 chk("t1_idle_wait", wait_exec, 0);
        cyc();                                  // START
        issue_valid = 1'b0;
        #1;
        chk("t1_start", unit_start, 4'b0100);
        chk("t1_start_wait", wait_exec, 1);
        chk("t1_start_rv", result_valid, 0);
        cyc();                                  // WAIT, ready high
        #1;
        chk("t1_wait_start", unit_start, 0);
        chk("t1_wait_exec", wait_exec, 0);
        chk("t1_wait_rv", result_valid, 0);
        cyc();                                  // result_valid 3 cycles after accept
        unit_ready = '0;
        #1;
        chk("t1_rv", result_valid, 1);
        chk("t1_result", result, 32'h3F80_0000);
        chk("t1_tag", result_tag, 7);
        chk("t1_wf", result_writef, 1);
        cyc();
        #1;
        chk("t1_rv_pulse", result_valid, 0);
        chk("t1_hold", result, 32'h3F80_0000);

        // Test 2: unit 0 ready after 10 WAIT cycles; ready on unit 2 is ignored.
        unit_data[0 +: DW] = 32'h0000_0041;
        unit_ready = 4'b0100;
        issue(4'b0001, 5'd3, 1'b0);
        n_high = 0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            issue_valid = 1'b0;
            #1;
            if (i == 0) chk("t2_start", unit_start, 4'b0001);
            if (i == 1) chk("t2_start_once", unit_start, 0);
            if (wait_exec) n_high++;
        end
        chk("t2_wait_cycles", n_high, 11);
        cyc();
        unit_ready = 4'b0101;
        #1 chk("t2_ready_wait", wait_exec, 0);
        cyc();
        unit_ready = '0;
        #1;
        chk("t2_rv", result_valid, 1);
        chk("t2_result", result, 32'h0000_0041);
        chk("t2_tag", result_tag, 3);
        chk("t2_wf", result_writef, 0);

        // Test 3: illegal selects.
        cyc();
        issue(4'b0011, 5'd1, 1'b0);
        cyc();
        issue_sel = 4'b0000;
        #1;
        chk("t3_err_multi", sel_err, 1);
        chk("t3_start_a", unit_start, 0);
        chk("t3_wait_a", wait_exec, 0);
        cyc();
        issue_valid = 1'b0;
        #1;
        chk("t3_err_zero", sel_err, 1);
        chk("t3_start_b", unit_start, 0);
        chk("t3_wait_b", wait_exec, 0);
        cyc();
        #1;
        chk("t3_err_clear", sel_err, 0);
        chk("t3_start_c", unit_start, 0);

        // Test 4: flush on WAIT cycle 2 with ready, then immediate reissue.
        unit_data[1*DW +: DW] = 32'h0000_1234;
        issue(4'b0010, 5'd9, 1'b1);
        cyc();                                  // START
        issue_valid = 1'b0;
        cyc();                                  // WAIT 1
        #1 chk("t4_w1_wait", wait_exec, 1);
        cyc();                                  // WAIT 2
        flush = 1'b1;
        unit_ready = 4'b0010;
        cyc();                                  // back in IDLE
        flush = 1'b0;
        unit_ready = '0;
        unit_data[3*DW +: DW] = 32'hCAFE_0001;
        issue(4'b1000, 5'd4, 1'b0);
        #1;
        chk("t4_flush_rv", result_valid, 0);
        chk("t4_flush_wait", wait_exec, 0);
        chk("t4_flush_hold", result, 32'h0000_0041);
        cyc();
        issue_valid = 1'b0;
        #1 chk("t4_reissue_start", unit_start, 4'b1000);
        cyc();
        unit_ready = 4'b1000;
        #1 chk("t4_ready_wait", wait_exec, 0);
        cyc();
        unit_ready = '0;
        #1;
        chk("t4_rv", result_valid, 1);
        chk("t4_result", result, 32'hCAFE_0001);
        chk("t4_tag", result_tag, 4);

        // Test 5: stall blocks acceptance, then reset during WAIT.
        cyc();
        stall = 1'b1;
        issue(4'b0100, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) stall = 1'b0;
            #1 chk("t5_stall_start", unit_start, 0);
        end
        cyc();
        issue_valid = 1'b0;
        #1 chk("t5_accept_start", unit_start, 4'b0100);
        cyc();                                  // WAIT, not ready
        rst = 1'b1;
        #1 chk("t5_wait", wait_exec, 1);
        cyc();
        rst = 1'b0;
        unit_ready = 4'b0100;
        #1;
        chk("t5_rst_start", unit_start, 0);
        chk("t5_rst_wait", wait_exec, 0);
        chk("t5_rst_result", result, 0);
        chk("t5_rst_tag", result_tag, 0);
        chk("t5_rst_wf", result_writef, 0);
        chk("t5_rst_rv", result_valid, 0);
        cyc();
        unit_ready = '0;
        #1 chk("t5_no_rv", result_valid, 0);

        // Test 6: unit never ready.
        issue(4'b0010, 5'd6, 1'b0);
        cyc();                                  // START
        issue_valid = 1'b0;
`ifdef EXEC_MC_TIMEOUT_EN
        n_high = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            if (wait_exec) n_high++;
            chk("t6_no_tmo_yet", timeout, 0);
        end
        chk("t6_wait_cycles", n_high, 8);
        cyc();
        #1;
        chk("t6_tmo", timeout, 1);
        chk("t6_tmo_rv", result_valid, 1);
        chk("t6_tmo_result", result, 32'hFFFF_FFFF);
        chk("t6_tmo_idle", wait_exec, 0);
`else
        n_high = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if (wait_exec) n_high++;
            if (timeout || result_valid) n_high = -100;
        end
        chk("t6_wait_forever", n_high, 20);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("t6_flush_wait", wait_exec, 0);
        chk("t6_flush_rv", result_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
